// File: rtl/ccip_tx_flow_steer_if.sv
// RPC handshake bundle between the NIC RPC pipeline, the flow steering stage and the
// CCI-P transmitter. The slave modport is the steering block; the master modport is its environment.
interface ccip_tx_flow_steer_if #(
  parameter int RPC_WIDTH         = 512,
  parameter int LMAX_NUM_OF_FLOWS = 1,
  parameter int LCONN_ID_WIDTH    = 16
);
  logic [RPC_WIDTH-1:0]         rpc_in;
  logic                         rpc_in_valid;
  logic [LCONN_ID_WIDTH-1:0]    rpc_conn_id_in;
  logic                         rpc_in_ready;
  logic                         ccip_tx_ready;
  logic [RPC_WIDTH-1:0]         rpc_out;
  logic                         rpc_out_valid;
  logic [LMAX_NUM_OF_FLOWS-1:0] rpc_flow_id_out;

  modport slave (
    input  rpc_in, rpc_in_valid, rpc_conn_id_in, ccip_tx_ready,
    output rpc_in_ready, rpc_out, rpc_out_valid, rpc_flow_id_out
  );

  modport master (
    output rpc_in, rpc_in_valid, rpc_conn_id_in, ccip_tx_ready,
    input  rpc_in_ready, rpc_out, rpc_out_valid, rpc_flow_id_out
  );
endinterface

// File: rtl/ccip_tx_flow_steer.sv
// Buffers incoming RPCs in a small FIFO, tags each with a TX flow ID (conn-ID or round-robin)
// and forwards one per cycle to the CCI-P transmitter; drains and counts drops while start is low.
module ccip_tx_flow_steer #(
  parameter int RPC_WIDTH         = 512,
  parameter int LMAX_NUM_OF_FLOWS = 1,
  parameter int LCONN_ID_WIDTH    = 16,
  parameter int LIN_FIFO_DEPTH    = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [LMAX_NUM_OF_FLOWS-1:0] number_of_flows,
  input  logic                         steer_mode,
  input  logic                         start,
  ccip_tx_flow_steer_if.slave          bus,
  output logic [31:0]                  fwd_cnt_out,
  output logic [31:0]                  drop_cnt_out
);
  localparam int L     = LMAX_NUM_OF_FLOWS;
  localparam int DEPTH = 1 << LIN_FIFO_DEPTH;

  typedef struct packed {
    logic [LCONN_ID_WIDTH-1:0] conn;
    logic [RPC_WIDTH-1:0]      rpc;
  } entry_t;

  entry_t                    mem_q [DEPTH];
  logic [LIN_FIFO_DEPTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LIN_FIFO_DEPTH:0]   count_q, count_d;
  logic                      stage_vld_q, stage_vld_d;
  logic [RPC_WIDTH-1:0]      stage_rpc_q, stage_rpc_d;
  logic [L-1:0]              stage_flow_q, stage_flow_d;
  logic [L-1:0]              rr_q, rr_d;
  logic                      out_vld_q, out_vld_d;
  logic [RPC_WIDTH-1:0]      rpc_out_q, rpc_out_d;
  logic [L-1:0]              flow_q, flow_d;
  logic [31:0]               fwd_cnt_q, fwd_cnt_d, drop_cnt_q, drop_cnt_d;

  logic   fifo_full, fifo_empty, in_ready, accept, push, pop, fwd_pop;
  entry_t head;

  // Conn-ID steering: fold an out-of-range index once, else fall back to flow 0.
  function automatic logic [L-1:0] conn_flow(input logic [L-1:0] idx, input logic [L-1:0] nf);
    logic [L:0] folded;
    folded = {1'b0, idx} - ({1'b0, nf} + (L+1)'(1));
    if (idx <= nf)                 return idx;
    else if (folded <= {1'b0, nf}) return folded[L-1:0];
    else                           return '0;
  endfunction

  assign fifo_full  = count_q[LIN_FIFO_DEPTH];
  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];

  // NOTE: every signal assigned in always_comb gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    in_ready     = start ? ~fifo_full : 1'b1;
    accept       = bus.rpc_in_valid & in_ready;
    push         = accept & start;
    pop          = ~fifo_empty & (~start | bus.ccip_tx_ready);
    fwd_pop      = pop & start;
    wr_ptr_d     = wr_ptr_q + LIN_FIFO_DEPTH'(push);
    rd_ptr_d     = rd_ptr_q + LIN_FIFO_DEPTH'(pop);
    count_d      = count_q + (LIN_FIFO_DEPTH+1)'(push) - (LIN_FIFO_DEPTH+1)'(pop);
    stage_vld_d  = fwd_pop;
    stage_rpc_d  = stage_rpc_q;
    stage_flow_d = stage_flow_q;
    rr_d         = rr_q;
    if (fwd_pop) begin
      stage_rpc_d = head.rpc;
      if (!steer_mode) begin
        stage_flow_d = conn_flow(head.conn[L-1:0], number_of_flows);
      end else if (rr_q > number_of_flows) begin
        stage_flow_d = '0;
        rr_d         = (number_of_flows == '0) ? '0 : L'(1);
      end else begin
        stage_flow_d = rr_q;
        rr_d         = (rr_q == number_of_flows) ? '0 : rr_q + L'(1);
      end
    end
    out_vld_d  = stage_vld_q;
    rpc_out_d  = stage_vld_q ? stage_rpc_q  : rpc_out_q;
    flow_d     = stage_vld_q ? stage_flow_q : flow_q;
    fwd_cnt_d  = fwd_cnt_q + 32'(stage_vld_q);
    // While stopped, an accepted RPC and a drained entry can both land in one cycle.
    drop_cnt_d = drop_cnt_q + 32'(accept & ~start) + 32'(pop & ~start);
  end

  // NOTE: the payload store has no reset; emptiness is tracked by count_q, so stale contents are never read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{conn: bus.rpc_conn_id_in, rpc: bus.rpc_in};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      stage_vld_q  <= 1'b0;
      stage_rpc_q  <= '0;
      stage_flow_q <= '0;
      rr_q         <= '0;
      out_vld_q    <= 1'b0;
      rpc_out_q    <= '0;
      flow_q       <= '0;
      fwd_cnt_q    <= '0;
      drop_cnt_q   <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      stage_vld_q  <= stage_vld_d;
      stage_rpc_q  <= stage_rpc_d;
      stage_flow_q <= stage_flow_d;
      rr_q         <= rr_d;
      out_vld_q    <= out_vld_d;
      rpc_out_q    <= rpc_out_d;
      flow_q       <= flow_d;
      fwd_cnt_q    <= fwd_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign bus.rpc_in_ready    = in_ready;
  assign bus.rpc_out         = rpc_out_q;
  assign bus.rpc_out_valid   = out_vld_q;
  assign bus.rpc_flow_id_out = flow_q;
  assign fwd_cnt_out         = fwd_cnt_q;
  assign drop_cnt_out        = drop_cnt_q;
endmodule

// File: doc/ccip_tx_flow_steer.md
Name: ccip_tx_flow_steer

Overview:
- Upstream neighbour of the CCI-P transmitter. Accepts RPCs from the NIC RPC pipeline over a valid/ready handshake and buffers them in a small input FIFO.
- Assigns each RPC a TX flow ID, either from its connection ID or round-robin.
- Presents one RPC per cycle on the transmitter's rpc_in / rpc_in_valid / rpc_flow_id_in interface, gated by ccip_tx_ready and start.
- Discards traffic while start is low and keeps forward/drop statistics.

Parameters:
- RPC_WIDTH, 512: width of the RPC payload (RpcIf).
- LMAX_NUM_OF_FLOWS, 1: log2 of the maximum number of TX flows; must match the transmitter.
- LCONN_ID_WIDTH, 16: width of the connection ID.
- LIN_FIFO_DEPTH, 2: log2 of the input FIFO depth (default 4 entries).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- number_of_flows  in  LMAX_NUM_OF_FLOWS  highest valid flow index (flows 0..number_of_flows)
- steer_mode  in  1  0 = connection-ID steering, 1 = round-robin
- start  in  1  enable forwarding
- rpc_in  in  RPC_WIDTH  RPC payload
- rpc_in_valid  in  1  payload valid
- rpc_conn_id_in  in  LCONN_ID_WIDTH  connection ID of rpc_in
- rpc_in_ready  out  1  block can accept an RPC this cycle
- ccip_tx_ready  in  1  transmitter / CCI-P channel not almost-full
- rpc_out  out  RPC_WIDTH  RPC to transmitter
- rpc_out_valid  out  1  one-cycle pulse per forwarded RPC
- rpc_flow_id_out  out  LMAX_NUM_OF_FLOWS  flow ID for rpc_out
- fwd_cnt_out  out  32  RPCs forwarded (wraps)
- drop_cnt_out  out  32  RPCs discarded (wraps)

Behaviour:
- Reset (async assert, deassert synchronous to clk) clears:
  - FIFO, making it empty;
  - rpc_out_valid, rpc_out, rpc_flow_id_out, fwd_cnt_out and drop_cnt_out, all to 0;
  - round-robin pointer, to 0.
- Reset mid-operation discards all buffered RPCs without counting them as drops.
- Input handshake:
  - rpc_in_ready = ~fifo_full when start=1; rpc_in_ready = 1 when start=0.
  - An RPC is accepted on an edge where rpc_in_valid & rpc_in_ready.
  - fifo_full comes from the registered count. A pop in the same cycle does not free a slot for a push while full; push and pop together when not full leave the count unchanged.
- While start=1, accepted RPCs are written to the FIFO together with their conn ID.
- While start=0:
  - accepted RPCs are discarded and drop_cnt increments by 1;
  - the FIFO also drains one entry per cycle, each drained entry incrementing drop_cnt;
  - if an RPC is accepted and an entry drained in the same cycle, drop_cnt increments by 2;
  - rpc_out_valid stays 0.
- Forwarding:
  - In any cycle with start=1, ccip_tx_ready=1 and the FIFO not empty, the head entry is popped.
  - On the next edge the block registers rpc_out, rpc_flow_id_out, rpc_out_valid=1 and fwd_cnt+1.
  - Otherwise rpc_out_valid=0 on that edge; rpc_out and rpc_flow_id_out hold their last values.
  - ccip_tx_ready low holds entries in the FIFO; nothing is dropped.
- Latency: an RPC accepted at edge N into an empty FIFO, with ccip_tx_ready=1 and start=1, gives rpc_out_valid=1 after edge N+2.
- Sustained throughput is 1 RPC/cycle.
- Flow mapping, steer_mode=0:
  - idx = rpc_conn_id_in[LMAX_NUM_OF_FLOWS-1:0];
  - flow = idx if idx <= number_of_flows;
  - else flow = idx - (number_of_flows+1) if that result is <= number_of_flows;
  - else flow = 0.
  - The mapping is computed from the conn ID stored with the entry, at pop time.
- Flow mapping, steer_mode=1:
  - flow = the round-robin pointer (rr). rr advances only on a forward.
  - rr wraps to 0 after reaching number_of_flows.
  - If rr > number_of_flows (after a control change), the forward uses flow 0 and rr becomes 1, or 0 when number_of_flows=0.
- Changing steer_mode or number_of_flows takes effect on the next pop; entries already in the FIFO are not remapped.
- Counters wrap from 2^32-1 to 0.
- No FIFO overflow is possible, because ready gating prevents it; an underflow pop is never issued.

Test Plan:
- Single RPC, steer_mode=0, number_of_flows=3, conn_id=0x0006, ccip_tx_ready=1, start=1, accepted at edge N → rpc_out_valid high after edge N+2 only, rpc_flow_id_out=2, fwd_cnt_out=1.
- steer_mode=1, number_of_flows=2, 7 back-to-back RPCs → flows 0,1,2,0,1,2,0 on consecutive cycles, fwd_cnt_out=7, rpc_in_ready never low.
- ccip_tx_ready=0, 6 RPCs offered (depth 4) → first 4 accepted, then rpc_in_ready=0. Raise ccip_tx_ready → 4 RPCs out in order, payloads matching, drop_cnt_out=0.
- FIFO holding 3 entries, start dropped to 0 while 2 more RPCs are offered in consecutive cycles → no rpc_out_valid, FIFO empty, drop_cnt_out=5.
- steer_mode=0, number_of_flows=2, LMAX_NUM_OF_FLOWS=2, conn_id low bits=3 → flow 0; number_of_flows=0, conn low bits=3 → flow 0; number_of_flows=1, low bits=3 → flow 1.
- Reset asserted asynchronously mid-stream with 2 entries buffered → rpc_out_valid=0 and counters=0 immediately, without waiting for a clk edge; after release, no stale RPC is emitted and the rr pointer restarts at flow 0.
